// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: shares one 32-bit Fibonacci LFSR between NUM_REQ
// requesters with round-robin arbitration. Each grant delivers one LFSR
// state, then the LFSR is advanced STEPS times before the next grant so
// consumers never see the same or adjacent states. After reset the LFSR
// is warmed up by WARMUP shifts before the first grant.
// Optional build macro LFSR_SEED_EN adds seed_load/seed_value for runtime
// reseeding (re-enters warm-up, keeps ptr and rand_out).
module lfsr_rand_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          STEPS   = 4,
    parameter int          WARMUP  = 32,
    parameter logic [31:0] SEED    = 32'h00000001
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef LFSR_SEED_EN
    input  logic               seed_load,
    input  logic [31:0]        seed_value,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rand_out,
    output logic               busy
);

    localparam int CNT_MAX = (WARMUP > STEPS) ? WARMUP : STEPS;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(NUM_REQ);

    localparam logic [CW-1:0] WARM_CNT  = CW'(WARMUP);
    localparam logic [CW-1:0] STEP_CNT  = CW'(STEPS);
    localparam logic [31:0]   SEED_SAFE = (SEED == 32'h0) ? 32'h00000001 : SEED;

    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_IDLE = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // A zero LFSR state would lock up, so it is replaced by 1.
    function automatic logic [31:0] zero_guard(input logic [31:0] v);
        return (v == 32'h0) ? 32'h00000001 : v;
    endfunction

    function automatic logic [31:0] lfsr_shift(input logic [31:0] v);
        return zero_guard({v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]});
    endfunction

    state_t               state_reg, state_next;
    logic [31:0]          lfsr_reg, lfsr_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [PW-1:0]        ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [31:0]          rand_reg, rand_next;

    logic                 seed_req;
    logic [31:0]          seed_word;

`ifdef LFSR_SEED_EN
    assign seed_req  = seed_load;
    assign seed_word = seed_value;
`else
    assign seed_req  = 1'b0;
    assign seed_word = 32'h0;
`endif

    // Rotated view of the request vector: position gi is requester ptr+gi.
    logic [PW:0]          cand_sum [NUM_REQ];
    logic [PW-1:0]        cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_req;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        win_inc;
    logic [NUM_REQ-1:0]   win_onehot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign cand_sum[gi] = {1'b0, ptr_reg} + (PW + 1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (PW + 1)'(NUM_REQ))
                                ? PW'(cand_sum[gi] - (PW + 1)'(NUM_REQ))
                                : PW'(cand_sum[gi]);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Winner is the first set request at or after ptr (lowest rotated slot).
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                win_idx = cand_idx[i];
            end
        end
        win_inc    = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
        win_onehot = NUM_REQ'(1) << win_idx;
    end

    // State register: synchronous active-low reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_WARM;
            lfsr_reg  <= SEED_SAFE;
            cnt_reg   <= WARM_CNT;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            rand_reg  <= 32'h0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            rand_reg  <= rand_next;
        end
    end

    // Next-state logic: warm-up shifts, idle arbitration, post-grant stepping.
    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        gnt_next   = '0;
        rand_next  = rand_reg;
        case (state_reg)
            ST_WARM: begin
                if (cnt_reg != '0) begin
                    lfsr_next = lfsr_shift(lfsr_reg);
                    cnt_next  = cnt_reg - CW'(1);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (|req) begin
                    gnt_next   = win_onehot;
                    rand_next  = lfsr_reg;
                    ptr_next   = win_inc;
                    cnt_next   = STEP_CNT;
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                lfsr_next = lfsr_shift(lfsr_reg);
                cnt_next  = cnt_reg - CW'(1);
                if (cnt_reg <= CW'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_WARM;
                cnt_next   = WARM_CNT;
            end
        endcase
        // Reseed restarts warm-up; ptr and the last delivered value survive.
        if (seed_req) begin
            lfsr_next  = zero_guard(seed_word);
            state_next = ST_WARM;
            cnt_next   = WARM_CNT;
            ptr_next   = ptr_reg;
            gnt_next   = '0;
            rand_next  = rand_reg;
        end
    end

    // Outputs: registered grant/value, busy whenever not idle.
    always_comb begin
        gnt      = gnt_reg;
        rand_out = rand_reg;
        busy     = (state_reg != ST_IDLE);
    end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Self-checking bench for lfsr_rand_arbiter (default build, no reseed port).
// A behavioural model tracks "busy cycles left" and "shifts left" counters
// and a rotating pointer; it is compared with the DUT on every negedge.
module tb_lfsr_rand_arbiter;

    localparam int          N  = 4;
    localparam int          ST = 2;
    localparam int          WU = 3;
    localparam logic [31:0] SD = 32'h00000001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [31:0]  rand_out;
    logic         busy;

    always #5 clk = ~clk;

    lfsr_rand_arbiter #(
        .NUM_REQ(N),
        .STEPS  (ST),
        .WARMUP (WU),
        .SEED   (SD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .rand_out(rand_out),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]  m_lfsr;
    logic [31:0]  m_rand;
    logic [N-1:0] m_gnt;
    int           m_busy_left;
    int           m_shift_left;
    int           m_ptr;
    bit           m_valid = 1'b0;

    function automatic logic [31:0] adv(input logic [31:0] v);
        logic [31:0] n;
        n = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
        return (n == 32'h0) ? 32'h1 : n;
    endfunction

    always @(posedge clk) begin
        int w;
        int c;
        if (!rst_n) begin
            m_valid      = 1'b1;
            m_lfsr       = (SD == 32'h0) ? 32'h1 : SD;
            m_busy_left  = WU + 1;
            m_shift_left = WU;
            m_ptr        = 0;
            m_gnt        = '0;
            m_rand       = 32'h0;
        end else if (m_valid) begin
            m_gnt = '0;
            if (m_busy_left > 0) begin
                if (m_shift_left > 0) begin
                    m_lfsr = adv(m_lfsr);
                    m_shift_left--;
                end
                m_busy_left--;
            end else if (req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (w < 0 && req[c]) w = c;
                end
                m_gnt        = N'(1) << w;
                m_rand       = m_lfsr;
                m_ptr        = (w + 1) % N;
                m_busy_left  = ST;
                m_shift_left = ST;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt", 32'(gnt), 32'(m_gnt));
            check("rand_out", rand_out, m_rand);
            check("busy", 32'(busy), (m_busy_left > 0) ? 32'd1 : 32'd0);
            check("gnt_onehot", ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (gnt != '0)
                $display("grant gnt=%b rand_out=%h", gnt, rand_out);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic count_busy(output int c);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            c++;
            @(negedge clk);
        end
    endtask

    task automatic wait_gnt(input string name, input logic [N-1:0] eg,
                            input logic [31:0] er, input bit chk_rand);
        int t;
        t = 0;
        @(negedge clk);
        while (gnt == '0 && t < 12) begin
            @(negedge clk);
            t++;
        end
        if (gnt == '0) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_gnt"}, 32'(gnt), 32'(eg));
            if (chk_rand) check({name, "_rand"}, rand_out, er);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bc;
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_rand", rand_out, 32'h0);
        check("reset_busy", 32'(busy), 32'h1);

        // Warm-up length and first values from a single requester
        rst_n = 1'b1;
        count_busy(bc);
        check("warmup_busy_cycles", 32'(bc), 32'd4);
        req = 4'b0010;
        wait_gnt("first", 4'b0010, 32'h0000000D, 1'b1);
        wait_gnt("second", 4'b0010, 32'h00000036, 1'b1);
        wait_gnt("third", 4'b0010, 32'h000000DB, 1'b1);

        // All requesting: round robin continues from ptr=2
        req = 4'b1111;
        wait_gnt("rr0", 4'b0100, 32'h0, 1'b0);
        wait_gnt("rr1", 4'b1000, 32'h0, 1'b0);
        wait_gnt("rr2", 4'b0001, 32'h0, 1'b0);
        wait_gnt("rr3", 4'b0010, 32'h0, 1'b0);

        // Reset during the first STEP cycle
        req = 4'b0001;
        wait_gnt("pre_reset", 4'b0001, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midstep_reset_gnt", 32'(gnt), 32'h0);
        check("midstep_reset_rand", rand_out, 32'h0);
        check("midstep_reset_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        count_busy(bc);
        check("rewarm_busy_cycles", 32'(bc), 32'd4);
        wait_gnt("after_reset", 4'b0001, 32'h0000000D, 1'b1);

        // Request raised and withdrawn during STEP: never granted, no idle shifting
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("withdrawn_no_gnt", 32'(gnt), 32'h0);
        end
        req = 4'b0100;
        wait_gnt("idle_hold", 4'b0100, 32'h00000036, 1'b1);
        req = '0;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            req   = N'($urandom_range(0, 15));
        end
        rst_n = 1'b1;
        req   = '0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
